// File: rtl/spi_command_slave.sv
// SPI mode-0 slave front end: oversampled SCK/CS/MOSI drive an 8-bit rx/tx shifter feeding the command FIFO.
// Optional `SPI_FIFO_GUARD_EN drops completed bytes while the downstream FIFO is full and flags overrun.
module spi_command_slave #(
    parameter int unsigned spi_fifo_length = 32,
    parameter int unsigned sync_stages     = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               spi_sck,
    input  logic                               spi_cs_n,
    input  logic                               spi_mosi,
    output logic                               spi_miso,
    output logic [7:0]                         command_out,
    output logic                               command_out_valid,
    input  logic [7:0]                         response_in,
    input  logic [$clog2(spi_fifo_length):0]   fifo_count,
    output logic                               overrun,
    output logic [15:0]                        bytes_received
);
    localparam int unsigned CNT_W  = $clog2(spi_fifo_length) + 1;
    localparam int unsigned PIPE_W = sync_stages + 2;
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(spi_fifo_length);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state_q, state_d;

    // [sync_stages-1] is the synchronised value, the next two flops feed edge detection
    logic [PIPE_W-1:0] sck_pipe_q, sck_pipe_d;
    logic [PIPE_W-1:0] cs_pipe_q, cs_pipe_d;
    logic [PIPE_W-2:0] mosi_pipe_q, mosi_pipe_d;

    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [7:0]  command_out_q, command_out_d;
    logic        valid_q, valid_d;
    logic        overrun_q, overrun_d;
    logic [15:0] bytes_q, bytes_d;

    logic sck_rise, sck_fall, cs_fall, cs_rise, mosi_s;
    logic byte_done, drop;

    assign sck_rise = sck_pipe_q[sync_stages] & ~sck_pipe_q[sync_stages+1];
    assign sck_fall = ~sck_pipe_q[sync_stages] & sck_pipe_q[sync_stages+1];
    assign cs_fall  = ~cs_pipe_q[sync_stages] & cs_pipe_q[sync_stages+1];
    assign cs_rise  = cs_pipe_q[sync_stages] & ~cs_pipe_q[sync_stages+1];
    assign mosi_s   = mosi_pipe_q[sync_stages];

`ifdef SPI_FIFO_GUARD_EN
    assign drop = (fifo_count == FIFO_FULL);
`else
    logic unused_fifo_count;
    assign unused_fifo_count = ^{fifo_count, FIFO_FULL};
    assign drop = 1'b0;
`endif

    always_comb begin
        sck_pipe_d    = {sck_pipe_q[PIPE_W-2:0], spi_sck};
        cs_pipe_d     = {cs_pipe_q[PIPE_W-2:0], spi_cs_n};
        mosi_pipe_d   = {mosi_pipe_q[PIPE_W-3:0], spi_mosi};
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        command_out_d = command_out_q;
        valid_d       = 1'b0;
        overrun_d     = overrun_q;
        bytes_d       = bytes_q;
        byte_done     = 1'b0;

        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (cs_fall) begin
                    tx_shift_d = response_in;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_fall) begin
                    bit_cnt_d  = '0;
                    tx_shift_d = response_in;
                end else begin
                    if (sck_rise) begin
                        rx_shift_d = {rx_shift_q[5:0], mosi_s};
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_done  = 1'b1;
                            tx_shift_d = response_in;
                        end
                    end else if (sck_fall && bit_cnt_q != 3'd0) begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                    // A byte completing on the CS-rise cycle is still delivered below
                    if (cs_rise) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                    end
                end
            end
        endcase

        if (byte_done) begin
            if (drop) begin
                overrun_d = 1'b1;
            end else begin
                command_out_d = {rx_shift_q, mosi_s};
                valid_d       = 1'b1;
                bytes_d       = bytes_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sck_pipe_q    <= '0;
            cs_pipe_q     <= '0;
            mosi_pipe_q   <= '0;
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            command_out_q <= '0;
            valid_q       <= 1'b0;
            overrun_q     <= 1'b0;
            bytes_q       <= '0;
        end else begin
            sck_pipe_q    <= sck_pipe_d;
            cs_pipe_q     <= cs_pipe_d;
            mosi_pipe_q   <= mosi_pipe_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            command_out_q <= command_out_d;
            valid_q       <= valid_d;
            overrun_q     <= overrun_d;
            bytes_q       <= bytes_d;
        end
    end

    assign spi_miso          = (state_q == SHIFT) & tx_shift_q[7];
    assign command_out       = command_out_q;
    assign command_out_valid = valid_q;
    assign overrun           = overrun_q;
    assign bytes_received    = bytes_q;

endmodule
